exe_stage_mc: RTL and testbench
===============================

// Module: exe_stage_mc
// PURPOSE
//  Parametrised execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM registers.
//  - Does 3-way operand forwarding (reg/MEM/WB), the ALU, branch condition and branch target.
//  - Adds an iterative multi-cycle MUL/DIVU/REMU unit, a registered output with valid/ready handshake,
//    and a flush input.
//  - Asserts busy to the hazard unit while a multi-cycle op is in flight.
// PARAMETERS
//  WIDTH     32  datapath width (>=8)
//  CNT_W     $clog2(WIDTH)+1  iteration counter width (derived, localparam)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      ID/EX presents an op
//  in_ready    out  1      op accepted on clk edge when in_valid & in_ready
//  flush       in   1      abort in-flight op and drop output
//  reg1,reg2   in   WIDTH  register operands
//  val2        in   WIDTH  immediate/second operand
//  pc          in   WIDTH  PC+4 of the op
//  exe_cmd     in   4      operation (pkg encoding)
//  br_type     in   2      00 none, 01 BEZ, 10 BNE, 11 JMP
//  sel1,sel2,sel3 in 2     fwd select for val1/val2/reg2: 00 own, 01 mem_value, 10 wb_value, 11 = own
//  mem_value,wb_value in WIDTH  forwarded values
//  out_valid   out  1      result registers hold a valid op
//  out_ready   in   1      EX/MEM consumes output on edge when out_valid & out_ready
//  alu_result  out  WIDTH  result
//  br_taken    out  1      branch taken (qualified by out_valid)
//  br_address  out  WIDTH  pc + (fwd val2 << 2), truncated to WIDTH
//  reg2_out    out  WIDTH  forwarded reg2 (store data)
//  busy        out  1      multi-cycle op in flight
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1. FSM=IDLE, counter=0. Reset mid-operation discards everything.
//  - in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
//  - Forwarding muxes are applied at accept. Forwarded operands are latched at accept;
//    later changes to mem_value/wb_value do not affect an in-flight op.
//  - ALU ops (1-cycle): ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111,
//    SLL 1000, SRA 1001, SRL 1010. Shift amount is val2[$clog2(WIDTH)-1:0].
//    Result appears with out_valid=1 on the edge after accept (latency 1).
//  - Multi-cycle ops: MUL 1100 (low WIDTH bits, shift-add), DIVU 1101, REMU 1110 (restoring, unsigned).
//    Undefined codes yield result 0, latency 1.
//  - Branch: BEZ taken iff val1==0; BNE iff val1!=reg2; JMP always; none -> 0. Computed at accept,
//    registered with the result. For multi-cycle ops br_taken=0.
//  - FSM states: IDLE, BUSY.
//    IDLE --accept MUL/DIVU/REMU--> BUSY, counter=WIDTH-1.
//    BUSY: one iteration per cycle, counter decrements. At counter==0 the result is written,
//      out_valid=1, state -> IDLE. Latency = WIDTH+1 cycles after accept.
//    busy = (state==BUSY).
//  - Divide by zero: DIVU -> all ones, REMU -> dividend. No exception.
//  - Output regs hold while out_valid & ~out_ready. The slot is always free on multi-cycle completion,
//    because accept requires it and BUSY blocks new accepts.
//  - flush (priority over all else): state -> IDLE, out_valid -> 0, no accept that cycle.
//    Flush during the completion cycle drops the result.
//  - Simultaneous consume + accept: allowed; out_valid stays 1 with the new result.
// STRUCTURE
//  - Package exe_pkg: EXE_CMD localparams, BR_* codes, FWD_* select codes, FSM state encoding.
//  - Sub-module exe_muldiv #(WIDTH): start, op, a, b -> done, result.
//    Holds the shift-add/restoring datapath and iteration counter.
//  - Top holds the forwarding muxes, ALU, branch logic, handshake, output registers and FSM.
// TESTING
//  - ADD fwd: reg1=5, sel1=01 mem_value=7, val2=3 -> next cycle out_valid=1, alu_result=10;
//    BEZ with val1=0 gives br_taken=1, br_address=pc+12.
//  - MUL WIDTH=32: 0x0001_0003*0x0000_0005 -> busy for 32 cycles, in_ready=0,
//    then result 0x0005_000F at cycle 33.
//  - DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFF_FFFF; REMU 9/0 -> 9.
//  - Backpressure: out_ready=0 for 4 cycles after an ADD -> outputs stable, in_ready=0;
//    out_ready=1 with in_valid -> back-to-back accept.
//  - Flush at BUSY cycle 10 and at the completion cycle -> out_valid stays 0, next op correct.
//    rst mid-BUSY -> all outputs 0.
//  - Operand latch: change wb_value every cycle during a sel1=10 MUL -> result uses the accept-cycle value.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU/muldiv commands, branch types,
// forwarding selects and the stage FSM states.
package exe_pkg;

    localparam logic [3:0] EXE_ADD  = 4'b0000;
    localparam logic [3:0] EXE_SUB  = 4'b0010;
    localparam logic [3:0] EXE_AND  = 4'b0100;
    localparam logic [3:0] EXE_OR   = 4'b0101;
    localparam logic [3:0] EXE_NOR  = 4'b0110;
    localparam logic [3:0] EXE_XOR  = 4'b0111;
    localparam logic [3:0] EXE_SLL  = 4'b1000;
    localparam logic [3:0] EXE_SRA  = 4'b1001;
    localparam logic [3:0] EXE_SRL  = 4'b1010;
    localparam logic [3:0] EXE_MUL  = 4'b1100;
    localparam logic [3:0] EXE_DIVU = 4'b1101;
    localparam logic [3:0] EXE_REMU = 4'b1110;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam logic [1:0] FWD_OWN = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {StIdle, StBusy} exe_state_e;

    function automatic logic is_multicycle(logic [3:0] cmd);
        return (cmd == EXE_MUL) || (cmd == EXE_DIVU) || (cmd == EXE_REMU);
    endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// done is asserted during the last iteration; result is that iteration's outcome.
module exe_muldiv
    import exe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [3:0]       op_q;
    // MUL: acc = product, shf = multiplier, opb = multiplicand.
    // DIV: acc = remainder, shf = dividend/quotient, opb = divisor.
    logic [WIDTH-1:0] acc_q, shf_q, opb_q;
    logic [WIDTH-1:0] acc_n, shf_n, opb_n;
    logic [WIDTH:0]   trial;

    always_comb begin
        acc_n = acc_q;
        shf_n = shf_q;
        opb_n = opb_q;
        trial = {acc_q, shf_q[WIDTH-1]} - {1'b0, opb_q};
        if (op_q == EXE_MUL) begin
            if (shf_q[0]) acc_n = acc_q + opb_q;
            shf_n = shf_q >> 1;
            opb_n = opb_q << 1;
        end else if (!trial[WIDTH]) begin
            acc_n = trial[WIDTH-1:0];
            shf_n = {shf_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = {acc_q[WIDTH-2:0], shf_q[WIDTH-1]};
            shf_n = {shf_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done   = run_q && (cnt_q == '0);
    assign result = (op_q == EXE_DIVU) ? shf_n : acc_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= EXE_ADD;
            acc_q <= '0;
            shf_q <= '0;
            opb_q <= '0;
        end else if (abort) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            op_q  <= op;
            cnt_q <= CNT_W'(WIDTH - 1);
            run_q <= 1'b1;
            acc_q <= '0;
            shf_q <= (op == EXE_MUL) ? b : a;
            opb_q <= (op == EXE_MUL) ? a : b;
        end else if (run_q) begin
            acc_q <= acc_n;
            shf_q <= shf_n;
            opb_q <= opb_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// MIPS execute stage: forwarding, single-cycle ALU, branch resolution, iterative
// MUL/DIVU/REMU and a registered valid/ready output with flush.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] pc,
    input  logic [3:0]       exe_cmd,
    input  logic [1:0]       br_type,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
    input  logic [1:0]       sel3,
    input  logic [WIDTH-1:0] mem_value,
    input  logic [WIDTH-1:0] wb_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_address,
    output logic [WIDTH-1:0] reg2_out,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    exe_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic             br_taken_q, br_taken_d;
    logic [WIDTH-1:0] br_address_q, br_address_d;
    logic [WIDTH-1:0] reg2_out_q, reg2_out_d;

    logic [WIDTH-1:0] val1_f, val2_f, reg2_f, alu_out, br_addr, md_result;
    logic [SH_W-1:0]  shamt;
    logic             br_cond, accept, mc_op, md_done;

    function automatic logic [WIDTH-1:0] fwd(logic [1:0] sel, logic [WIDTH-1:0] own,
                                             logic [WIDTH-1:0] mv, logic [WIDTH-1:0] wv);
        case (sel)
            FWD_MEM: return mv;
            FWD_WB:  return wv;
            default: return own;
        endcase
    endfunction

    assign val1_f = fwd(sel1, reg1, mem_value, wb_value);
    assign val2_f = fwd(sel2, val2, mem_value, wb_value);
    assign reg2_f = fwd(sel3, reg2, mem_value, wb_value);
    assign shamt  = val2_f[SH_W-1:0];
    assign mc_op  = is_multicycle(exe_cmd);

    always_comb begin
        alu_out = '0;
        case (exe_cmd)
            EXE_ADD: alu_out = val1_f + val2_f;
            EXE_SUB: alu_out = val1_f - val2_f;
            EXE_AND: alu_out = val1_f & val2_f;
            EXE_OR:  alu_out = val1_f | val2_f;
            EXE_NOR: alu_out = ~(val1_f | val2_f);
            EXE_XOR: alu_out = val1_f ^ val2_f;
            EXE_SLL: alu_out = val1_f << shamt;
            EXE_SRA: alu_out = $unsigned($signed(val1_f) >>> shamt);
            EXE_SRL: alu_out = val1_f >> shamt;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_BEZ:  br_cond = (val1_f == '0);
            BR_BNE:  br_cond = (val1_f != reg2_f);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
        if (mc_op) br_cond = 1'b0;
    end

    assign br_addr  = pc + (val2_f << 2);
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    exe_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (accept && mc_op),
        .abort (flush),
        .op    (exe_cmd),
        .a     (val1_f),
        .b     (val2_f),
        .done  (md_done),
        .result(md_result)
    );

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        alu_d        = alu_q;
        br_taken_d   = br_taken_q;
        br_address_d = br_address_q;
        reg2_out_d   = reg2_out_q;
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            if (accept) begin
                // Side outputs of a multi-cycle op are parked early; out_valid stays low.
                br_taken_d   = br_cond;
                br_address_d = br_addr;
                reg2_out_d   = reg2_f;
                if (mc_op) begin
                    state_d = StBusy;
                end else begin
                    out_valid_d = 1'b1;
                    alu_d       = alu_out;
                end
            end else if ((state_q == StBusy) && md_done) begin
                out_valid_d = 1'b1;
                alu_d       = md_result;
                state_d     = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            alu_q        <= '0;
            br_taken_q   <= 1'b0;
            br_address_q <= '0;
            reg2_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            alu_q        <= alu_d;
            br_taken_q   <= br_taken_d;
            br_address_q <= br_address_d;
            reg2_out_q   <= reg2_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = alu_q;
    assign br_taken   = br_taken_q;
    assign br_address = br_address_q;
    assign reg2_out   = reg2_out_q;
    assign busy       = (state_q == StBusy);

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: expected results are queued at accept and
// compared when the stage presents them.
module tb_exe_stage_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, flush, out_valid, out_ready, br_taken, busy;
    logic [W-1:0] reg1, reg2, val2, pc, mem_value, wb_value, alu_result, br_address, reg2_out;
    logic [3:0]   exe_cmd;
    logic [1:0]   br_type, sel1, sel2, sel3;

    typedef struct packed {
        logic [W-1:0] alu;
        logic         br;
        logic [W-1:0] addr;
        logic [W-1:0] r2;
    } res_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    exe_stage_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .reg1      (reg1),
        .reg2      (reg2),
        .val2      (val2),
        .pc        (pc),
        .exe_cmd   (exe_cmd),
        .br_type   (br_type),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .mem_value (mem_value),
        .wb_value  (wb_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_result(alu_result),
        .br_taken  (br_taken),
        .br_address(br_address),
        .reg2_out  (reg2_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fwd(logic [1:0] s, logic [W-1:0] own);
        if (s == 2'b01) return mem_value;
        if (s == 2'b10) return wb_value;
        return own;
    endfunction

    function automatic res_t model(logic [3:0] c, logic [1:0] b, logic [W-1:0] a,
                                   logic [W-1:0] v, logic [W-1:0] r, logic [W-1:0] p);
        res_t e;
        logic mc;
        mc = (c == 4'b1100) || (c == 4'b1101) || (c == 4'b1110);
        case (c)
            4'b0000: e.alu = a + v;
            4'b0010: e.alu = a - v;
            4'b0100: e.alu = a & v;
            4'b0101: e.alu = a | v;
            4'b0110: e.alu = ~(a | v);
            4'b0111: e.alu = a ^ v;
            4'b1000: e.alu = a << v[4:0];
            4'b1001: e.alu = $unsigned($signed(a) >>> v[4:0]);
            4'b1010: e.alu = a >> v[4:0];
            4'b1100: e.alu = a * v;
            4'b1101: e.alu = (v == 0) ? '1 : a / v;
            4'b1110: e.alu = (v == 0) ? a : a % v;
            default: e.alu = '0;
        endcase
        case (b)
            2'b01:   e.br = (a == 0);
            2'b10:   e.br = (a != r);
            2'b11:   e.br = 1'b1;
            default: e.br = 1'b0;
        endcase
        if (mc) e.br = 1'b0;
        e.addr = p + (v << 2);
        e.r2   = r;
        return e;
    endfunction

    function automatic res_t cur_exp();
        return model(exe_cmd, br_type, fwd(sel1, reg1), fwd(sel2, val2), fwd(sel3, reg2), pc);
    endfunction

    function automatic res_t pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    task automatic set_op(input logic [3:0] c, input logic [1:0] b, input logic [W-1:0] r1,
                          input logic [W-1:0] r2, input logic [W-1:0] v2, input logic [W-1:0] p,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
        exe_cmd = c; br_type = b; reg1 = r1; reg2 = r2; val2 = v2; pc = p;
        sel1 = s1; sel2 = s2; sel3 = s3; in_valid = 1'b1;
    endtask

    // Waits for the op on the inputs to be accepted and queues its expected result.
    task automatic drive_op();
        res_t e;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = cur_exp();
                @(posedge clk);
                #1 in_valid = 1'b0;
                exp_q.push_back(e);
                return;
            end
        end
        checks++; failures++;
        $display("FAIL accept_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int max, input bit wiggle, output res_t got, output int cyc,
                           output int busy_n, output bit rdy_busy);
        cyc = 0; busy_n = 0; rdy_busy = 1'b0; got = '0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                got = {alu_result, br_taken, br_address, reg2_out};
                @(posedge clk);
                #1;
                return;
            end
            if (busy) busy_n++;
            if (busy && in_ready) rdy_busy = 1'b1;
            if (wiggle) begin
                wb_value  = $urandom;
                mem_value = $urandom;
            end
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, br_taken, busy} !== 3'b000 || alu_result !== 0 || br_address !== 0 ||
            reg2_out !== 0) begin
            failures++;
            $display("FAIL reset_outputs: valid/br/busy=%b alu=%h addr=%h r2=%h required all 0",
                     {out_valid, br_taken, busy}, alu_result, br_address, reg2_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: valid=%b busy=%b in_ready=%b required 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_alu();
        res_t got, e;
        int cyc, bn;
        bit rb;
        logic [3:0] cmds[11];
        cmds = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h3, 4'hF};
        mem_value = 32'd7;
        set_op(4'b0000, 2'b00, 32'd5, 32'd0, 32'd3, 32'h100, 2'b01, 2'b00, 2'b00);
        drive_op();
        collect(5, 1'b0, got, cyc, bn, rb);
        void'(pop_exp());
        checks++;
        if (got.alu !== 32'd10 || cyc != 1) begin
            failures++;
            $display("FAIL add_fwd: alu=%0d cyc=%0d required 10 1", got.alu, cyc);
        end
        set_op(4'b0000, 2'b01, 32'd0, 32'd0, 32'd3, 32'h100, 2'b00, 2'b00, 2'b00);
        drive_op();
        collect(5, 1'b0, got, cyc, bn, rb);
        void'(pop_exp());
        checks++;
        if (got.br !== 1'b1 || got.addr !== 32'h10C || cyc != 1) begin
            failures++;
            $display("FAIL bez: br=%b addr=%h cyc=%0d required 1 0000010c 1",
                     got.br, got.addr, cyc);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 11; i++) begin
                mem_value = $urandom;
                wb_value  = $urandom;
                set_op(cmds[i], 2'($urandom_range(0, 3)), (r == 1 && i < 3) ? 32'd0 : $urandom,
                       $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                drive_op();
                collect(5, 1'b0, got, cyc, bn, rb);
                e = pop_exp();
                checks++;
                if (got !== e || cyc != 1) begin
                    failures++;
                    $display("FAIL alu_cmd_%h: got=%h cyc=%0d required %h 1", cmds[i], got, cyc, e);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        res_t got, e;
        int cyc, bn;
        bit rb;
        logic [3:0]   c[4];
        logic [W-1:0] a[4], b[4], want[4];
        c = '{4'b1101, 4'b1110, 4'b1101, 4'b1110};
        a = '{32'd100, 32'd100, 32'h1234_5678, 32'd9};
        b = '{32'd7, 32'd7, 32'd0, 32'd0};
        want = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
        set_op(4'b1100, 2'b11, 32'h0001_0003, 32'h55, 32'h5, 32'h0, 2'b00, 2'b00, 2'b00);
        drive_op();
        collect(60, 1'b0, got, cyc, bn, rb);
        e = pop_exp();
        checks++;
        if (got.alu !== 32'h0005_000F || got !== e || cyc != 33) begin
            failures++;
            $display("FAIL mul_basic: got=%h cyc=%0d required alu 0005000f br 0 cyc 33", got, cyc);
        end
        checks++;
        if (bn != 32 || rb) begin
            failures++;
            $display("FAIL mul_busy: busy_cycles=%0d ready_while_busy=%b required 32 0", bn, rb);
        end
        for (int i = 0; i < 4; i++) begin
            set_op(c[i], 2'b00, a[i], 32'h0, b[i], 32'h40, 2'b00, 2'b00, 2'b00);
            drive_op();
            collect(60, 1'b0, got, cyc, bn, rb);
            void'(pop_exp());
            checks++;
            if (got.alu !== want[i] || cyc != 33) begin
                failures++;
                $display("FAIL div_%0d: alu=%h cyc=%0d required %h 33", i, got.alu, cyc, want[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            mem_value = $urandom;
            wb_value  = $urandom_range(1, 5000);
            set_op(4'b1100 + 4'(i % 3), 2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom_range(1, 70000), $urandom, 2'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            drive_op();
            collect(60, 1'b0, got, cyc, bn, rb);
            e = pop_exp();
            checks++;
            if (got !== e || cyc != 33) begin
                failures++;
                $display("FAIL muldiv_rand_%0d: got=%h cyc=%0d required %h 33", i, got, cyc, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, e1, e2;
        out_ready = 1'b0;
        set_op(4'b0000, 2'b10, 32'd40, 32'd41, 32'd2, 32'h200, 2'b00, 2'b00, 2'b00);
        drive_op();
        e1 = pop_exp();
        set_op(4'b0111, 2'b00, 32'hF0F0, 32'h1, 32'h0FF0, 32'h300, 2'b00, 2'b00, 2'b00);
        e2 = cur_exp();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {alu_result, br_taken, br_address, reg2_out};
            checks++;
            if (out_valid !== 1'b1 || got !== e1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_%0d: valid=%b got=%h in_ready=%b required 1 %h 0",
                         i, out_valid, got, in_ready, e1);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL consume_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        got = {alu_result, br_taken, br_address, reg2_out};
        checks++;
        if (out_valid !== 1'b1 || got !== e2) begin
            failures++;
            $display("FAIL back_to_back: valid=%b got=%h required 1 %h", out_valid, got, e2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        res_t got, e;
        int cyc, bn, seen;
        bit rb;
        set_op(4'b1100, 2'b00, 32'd123, 32'd0, 32'd456, 32'h0, 2'b00, 2'b00, 2'b00);
        drive_op();
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        exp_q.delete();
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_busy: valid_or_busy_cycles=%0d required 0", seen);
        end
        set_op(4'b1101, 2'b00, 32'd1000, 32'd0, 32'd10, 32'h0, 2'b00, 2'b00, 2'b00);
        drive_op();
        repeat (31) @(posedge clk);
        #1 flush = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_completion_busy: busy=%b required 1", busy);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        exp_q.delete();
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_completion: valid_or_busy_cycles=%0d required 0", seen);
        end
        set_op(4'b0010, 2'b00, 32'd50, 32'd0, 32'd8, 32'h0, 2'b00, 2'b00, 2'b00);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_accept: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        drive_op();
        collect(5, 1'b0, got, cyc, bn, rb);
        e = pop_exp();
        checks++;
        if (got !== e || got.alu !== 32'd42 || cyc != 1) begin
            failures++;
            $display("FAIL after_flush: got=%h cyc=%0d required %h 1", got, cyc, e);
        end
    endtask

    task automatic test_reset_busy();
        res_t got, e;
        int cyc, bn;
        bit rb;
        set_op(4'b1100, 2'b11, 32'hDEAD, 32'hBEEF, 32'h77, 32'h1000, 2'b00, 2'b00, 2'b00);
        drive_op();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, br_taken, busy} !== 3'b000 || alu_result !== 0 || br_address !== 0 ||
            reg2_out !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy: v/br/busy=%b alu=%h addr=%h r2=%h rdy=%b req 0s rdy 1",
                     {out_valid, br_taken, busy}, alu_result, br_address, reg2_out, in_ready);
        end
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        set_op(4'b0101, 2'b01, 32'h0, 32'h3, 32'h30, 32'h20, 2'b00, 2'b00, 2'b00);
        drive_op();
        collect(5, 1'b0, got, cyc, bn, rb);
        e = pop_exp();
        checks++;
        if (got !== e || cyc != 1) begin
            failures++;
            $display("FAIL after_reset_op: got=%h cyc=%0d required %h 1", got, cyc, e);
        end
    endtask

    task automatic test_operand_latch();
        res_t got, e;
        int cyc, bn;
        bit rb;
        wb_value = 32'h1234;
        set_op(4'b1100, 2'b00, 32'd99, 32'd0, 32'h11, 32'h0, 2'b10, 2'b00, 2'b00);
        drive_op();
        collect(60, 1'b1, got, cyc, bn, rb);
        e = pop_exp();
        checks++;
        if (got.alu !== 32'h0001_3574 || got !== e || cyc != 33) begin
            failures++;
            $display("FAIL latch_mul: got=%h cyc=%0d required alu 00013574 cyc 33", got, cyc);
        end
        mem_value = 32'd5;
        wb_value  = 32'd1003;
        set_op(4'b1110, 2'b00, 32'd0, 32'd0, 32'd0, 32'h0, 2'b10, 2'b01, 2'b01);
        drive_op();
        collect(60, 1'b1, got, cyc, bn, rb);
        e = pop_exp();
        checks++;
        if (got.alu !== 32'd3 || got !== e || cyc != 33) begin
            failures++;
            $display("FAIL latch_remu: got=%h cyc=%0d required alu 3 cyc 33", got, cyc);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        reg1 = '0; reg2 = '0; val2 = '0; pc = '0; exe_cmd = '0; br_type = '0;
        sel1 = '0; sel2 = '0; sel3 = '0; mem_value = '0; wb_value = '0;
        test_reset();
        test_alu();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        test_operand_latch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
